// File: rtl/nasti_mover_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : nasti_mover_sched_if
//  Description : Bundles every request-side and mover-side handshake signal
//                of the shared stream-mover scheduler.
//                  slave  : the scheduler's view (takes requests, drives the
//                           mover request, receives mover ready).
//                  master : the environment's view (requesters plus mover).
//                Signals:
//                  req_src / req_len   N_REQ*ADDR_WIDTH  packed per requester
//                  req_valid           N_REQ             request valid
//                  req_ready           N_REQ             request accept
//                  done / err          N_REQ             one-cycle pulses
//                  m_src / m_len       ADDR_WIDTH        mover request
//                  m_valid / m_ready   1                 mover handshake
//  Revision    : 1.0 - initial release
// ============================================================================
interface nasti_mover_sched_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64
);
  logic [N_REQ*ADDR_WIDTH-1:0] req_src;
  logic [N_REQ*ADDR_WIDTH-1:0] req_len;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            done;
  logic [N_REQ-1:0]            err;
  logic [ADDR_WIDTH-1:0]       m_src;
  logic [ADDR_WIDTH-1:0]       m_len;
  logic                        m_valid;
  logic                        m_ready;

  modport slave (
    input  req_src, req_len, req_valid, m_ready,
    output req_ready, done, err, m_src, m_len, m_valid
  );

  modport master (
    output req_src, req_len, req_valid, m_ready,
    input  req_ready, done, err, m_src, m_len, m_valid
  );
endinterface
`default_nettype wire

// File: rtl/nasti_mover_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nasti_mover_sched
//  Description : Round-robin scheduler that shares one stream mover between
//                N_REQ requesters. Requests are checked for beat alignment;
//                misaligned ones are rejected with err, zero-length ones are
//                completed immediately with done, the rest are issued to the
//                mover and tracked until the mover returns to idle.
//                Ports:
//                  aclk      in   clock, rising edge
//                  areset    in   synchronous active-high reset
//                  bus       if   requester and mover handshakes (slave view)
//                  busy      out  scheduler not in IDLE
//                  owner     out  index of granted requester (valid while busy)
//                  xfer_cnt  out  completed mover transfers, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module nasti_mover_sched #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     aclk,
  input  logic                     areset,
  nasti_mover_sched_if.slave       bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [15:0]              xfer_cnt
);

  localparam int                    c_OWN_W      = $clog2(N_REQ);
  localparam int                    c_IDX_W      = c_OWN_W + 1;
  localparam int                    c_BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'(c_BEAT_BYTES - 1);
  localparam logic [N_REQ-1:0]      c_ONE        = N_REQ'(1);
  localparam logic [c_OWN_W-1:0]    c_LAST       = c_OWN_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [c_OWN_W-1:0]      r_ptr;
  logic [c_OWN_W-1:0]      r_owner;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic [ADDR_WIDTH-1:0]   r_len;
  logic [N_REQ-1:0]        r_done_zl;
  logic [N_REQ-1:0]        r_err;
  logic [15:0]             r_xfer_cnt;

  logic                    w_found;
  logic [c_OWN_W-1:0]      w_win;
  logic                    w_accept;
  logic [N_REQ-1:0]        w_grant_1h;
  logic [ADDR_WIDTH-1:0]   w_sel_src;
  logic [ADDR_WIDTH-1:0]   w_sel_len;
  logic                    w_misaligned;
  logic                    w_zero_len;

  // --------------------------------------------------------------------------
  // Rotating priority search: ptr has highest priority, then ptr+1, ... with
  // wrap at N_REQ. The sum is one bit wider so the wrap works for any N_REQ,
  // not only powers of two.
  // --------------------------------------------------------------------------
  always_comb begin : p_arb
    logic [c_IDX_W-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = {1'b0, r_ptr} + c_IDX_W'(k);
      if (v_idx >= c_IDX_W'(N_REQ)) begin
        v_idx = v_idx - c_IDX_W'(N_REQ);
      end
      if (!w_found && bus.req_valid[v_idx[c_OWN_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[c_OWN_W-1:0];
      end
    end
  end

  // Grants only happen in IDLE and never while reset is held, so req_ready
  // is gated by areset combinationally as well.
  assign w_accept     = (r_state == S_IDLE) && w_found && !areset;
  assign w_grant_1h   = c_ONE << w_win;
  assign w_sel_src    = bus.req_src[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_len    = bus.req_len[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_misaligned = |((w_sel_src | w_sel_len) & c_ALIGN_MASK);
  assign w_zero_len   = (w_sel_len == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. m_valid is high exactly in ISSUE, so the mover
  // handshake in ISSUE reduces to m_ready. The mover drops m_ready for the
  // duration of a transfer, so WAIT_START waits for that drop and WAIT_DONE
  // for the return to idle.
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_nxt
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_misaligned && !w_zero_len) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.m_ready) begin
          w_state_nxt = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (!bus.m_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.m_ready) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch, round-robin pointer, immediate responses for
  // rejected / empty requests, transfer counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_src      <= '0;
      r_len      <= '0;
      r_done_zl  <= '0;
      r_err      <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_done_zl <= '0;
      r_err     <= '0;
      if (w_accept) begin
        r_ptr   <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
        r_owner <= w_win;
        r_src   <= w_sel_src;
        r_len   <= w_sel_len;
        if (w_misaligned) begin
          r_err <= w_grant_1h;
        end else if (w_zero_len) begin
          r_done_zl <= w_grant_1h;
        end
      end
      if (r_state == S_FINISH) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. A zero-length completion is only ever produced in the cycle
  // after an IDLE accept, and FINISH is never entered directly from IDLE,
  // so the two done sources cannot overlap.
  // --------------------------------------------------------------------------
  assign bus.req_ready = w_accept ? w_grant_1h : '0;
  assign bus.m_valid   = (r_state == S_ISSUE);
  assign bus.m_src     = r_src;
  assign bus.m_len     = r_len;
  assign bus.done      = r_done_zl | ((r_state == S_FINISH) ? (c_ONE << r_owner) : '0);
  assign bus.err       = r_err;
  assign busy          = (r_state != S_IDLE);
  assign owner         = r_owner;
  assign xfer_cnt      = r_xfer_cnt;

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_ready_onehot: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(bus.req_ready));

  a_ready_idle_only: assert property (@(posedge aclk) disable iff (areset)
    (r_state != S_IDLE) |-> (bus.req_ready == '0));

  a_resp_exclusive: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(bus.done | bus.err) && ((bus.done & bus.err) == '0));

endmodule
`default_nettype wire

// File: tb/tb_nasti_mover_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nasti_mover_sched
//  Description : Scoreboard bench for nasti_mover_sched. Stimulus pushes the
//                expected grants, mover requests and done/err pulses into
//                queues; a monitor pops and compares whenever the DUT shows
//                a grant, a response pulse or a new mover request. A small
//                mover model answers the mover handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nasti_mover_sched;

  localparam int N_REQ      = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int c_OWN_W    = $clog2(N_REQ);

  logic               aclk   = 1'b0;
  logic               areset = 1'b1;
  logic               busy;
  logic [c_OWN_W-1:0] owner;
  logic [15:0]        xfer_cnt;

  nasti_mover_sched_if #(.N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  nasti_mover_sched #(
    .N_REQ      (N_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .bus      (bus),
    .busy     (busy),
    .owner    (owner),
    .xfer_cnt (xfer_cnt)
  );

  // Rising edges at 10, 30, ...; falling edges at 20, 40, ...
  // Per cycle after the falling edge: +1 stimulus, +2 drive, +3 monitor,
  // +4 stimulus-side checks, +5 accept bookkeeping.
  always #10 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit is_err; int idx; } resp_t;
  typedef struct { logic [63:0] src; logic [63:0] len; } mov_t;

  int    exp_grant[$];
  resp_t exp_resp[$];
  mov_t  exp_mov[$];

  int          pend  [N_REQ] = '{default: 0};
  logic [63:0] src_v [N_REQ] = '{default: 64'h0};
  logic [63:0] len_v [N_REQ] = '{default: 64'h0};

  int mover_lat  = 10;
  int stall_left = 0;
  int busy_left  = 0;
  bit hs         = 1'b0;
  bit rst_seen   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pend_total();
    int s;
    s = 0;
    for (int i = 0; i < N_REQ; i++) s += pend[i];
    return s;
  endfunction

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
    #4;
  endtask

  task automatic set_req(input int i, input logic [63:0] s, input logic [63:0] l, input int n);
    src_v[i] = s;
    len_v[i] = l;
    pend[i]  = n;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      sample();
      if (!busy && exp_grant.size() == 0 && exp_resp.size() == 0 &&
          exp_mov.size() == 0 && pend_total() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_within_budget", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_mvalid(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      sample();
      if (bus.m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("m_valid_within_budget", {63'd0, seen}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_owner"},     64'(owner),         64'd0);
    check({tag, "_xfer_cnt"},  64'(xfer_cnt),      64'd0);
    check({tag, "_m_valid"},   64'(bus.m_valid),   64'd0);
    check({tag, "_m_src"},     bus.m_src,          64'd0);
    check({tag, "_m_len"},     bus.m_len,          64'd0);
    check({tag, "_done"},      64'(bus.done),      64'd0);
    check({tag, "_err"},       64'(bus.err),       64'd0);
  endtask

  // ---------------------------------------------------------------- requesters
  initial begin
    bus.req_valid = '0;
    bus.req_src   = '0;
    bus.req_len   = '0;
    forever begin
      @(negedge aclk);
      #2;
      for (int i = 0; i < N_REQ; i++) begin
        bus.req_valid[i]                          = (pend[i] > 0);
        bus.req_src[i*ADDR_WIDTH +: ADDR_WIDTH]   = src_v[i];
        bus.req_len[i*ADDR_WIDTH +: ADDR_WIDTH]   = len_v[i];
      end
      #3;
      for (int i = 0; i < N_REQ; i++) begin
        if (!areset && bus.req_valid[i] && bus.req_ready[i]) pend[i]--;
      end
    end
  end

  // ---------------------------------------------------------------- mover
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(negedge aclk);
      #2;
      if (rst_seen) begin
        bus.m_ready = 1'b1;
        busy_left   = 0;
      end else if (hs) begin
        bus.m_ready = 1'b0;
        busy_left   = mover_lat;
      end else if (busy_left > 1) begin
        busy_left--;
      end else if (busy_left == 1) begin
        busy_left   = 0;
        bus.m_ready = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        bus.m_ready = 1'b0;
      end else begin
        bus.m_ready = 1'b1;
      end
      #3;
      rst_seen = areset;
      hs       = bus.m_valid && bus.m_ready && !areset;
    end
  end

  // ---------------------------------------------------------------- monitor
  logic                 prev_mv = 1'b0;
  int                   mon_g;
  resp_t                mon_r;
  mov_t                 mon_m;
  logic [2*N_REQ-1:0]   mon_ev;

  initial begin
    forever begin
      @(negedge aclk);
      #3;
      if (bus.req_ready !== '0) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", 64'(bus.req_ready), 64'd0);
        end else begin
          mon_g = exp_grant.pop_front();
          check("grant", 64'(bus.req_ready), 64'd1 << mon_g);
        end
      end
      if ((bus.done | bus.err) !== '0) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_done_err", 64'({bus.err, bus.done}), 64'd0);
        end else begin
          mon_r  = exp_resp.pop_front();
          mon_ev = '0;
          mon_ev[mon_r.is_err ? N_REQ + mon_r.idx : mon_r.idx] = 1'b1;
          check(mon_r.is_err ? "err_pulse" : "done_pulse", 64'({bus.err, bus.done}), 64'(mon_ev));
        end
      end
      if (bus.m_valid && !prev_mv) begin
        if (exp_mov.size() == 0) begin
          check("unexpected_m_valid", 64'(bus.m_valid), 64'd0);
        end else begin
          mon_m = exp_mov.pop_front();
          check("m_src", bus.m_src, mon_m.src);
          check("m_len", bus.m_len, mon_m.len);
        end
      end
      prev_mv = bus.m_valid;
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset with requester 1 already asserting a zero-length request.
    set_req(1, 64'h2000, 64'h0, 1);
    repeat (2) step();
    sample();
    check_reset_state("reset");

    // Release: requester 1 granted, done the next cycle, no mover activity.
    step();
    exp_grant.push_back(1);
    exp_resp.push_back('{1'b0, 1});
    areset = 1'b0;
    wait_idle(20);
    check("zero_len_xfer_cnt", 64'(xfer_cnt), 64'd0);

    // Single real transfer from requester 0 (ptr = 2, only req0 valid).
    step();
    mover_lat = 10;
    exp_grant.push_back(0);
    exp_mov.push_back('{64'h1000, 64'h40});
    exp_resp.push_back('{1'b0, 0});
    set_req(0, 64'h1000, 64'h40, 1);
    wait_idle(40);
    check("single_xfer_cnt", 64'(xfer_cnt), 64'd1);

    // Misaligned source from requester 2: err only, ptr moves to 3.
    step();
    exp_grant.push_back(2);
    exp_resp.push_back('{1'b1, 2});
    set_req(2, 64'h1004, 64'h40, 1);
    wait_idle(20);
    check("misaligned_xfer_cnt", 64'(xfer_cnt), 64'd1);

    // Requesters 0 and 3 together: ptr = 3 so 3 wins first.
    step();
    mover_lat = 3;
    exp_grant.push_back(3);
    exp_mov.push_back('{64'h3000, 64'h80});
    exp_resp.push_back('{1'b0, 3});
    exp_grant.push_back(0);
    exp_mov.push_back('{64'h7000, 64'h40});
    exp_resp.push_back('{1'b0, 0});
    set_req(3, 64'h3000, 64'h80, 1);
    set_req(0, 64'h7000, 64'h40, 1);
    wait_idle(60);
    check("pair_xfer_cnt", 64'(xfer_cnt), 64'd3);

    // Requester 3 zero length alone: brings ptr back to 0.
    step();
    exp_grant.push_back(3);
    exp_resp.push_back('{1'b0, 3});
    set_req(3, 64'h3100, 64'h0, 1);
    wait_idle(20);

    // All four valid continuously from ptr = 0: order 0,1,2,3,0.
    step();
    mover_lat = 3;
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, 64'h10000 + 64'(i) * 64'h100, 64'(8 * (i + 1)), (i == 0) ? 2 : 1);
    end
    for (int k = 0; k < 5; k++) begin
      exp_grant.push_back(k % N_REQ);
      exp_mov.push_back('{64'h10000 + 64'(k % N_REQ) * 64'h100, 64'(8 * ((k % N_REQ) + 1))});
      exp_resp.push_back('{1'b0, k % N_REQ});
    end
    wait_idle(200);
    check("rr_xfer_cnt", 64'(xfer_cnt), 64'd8);

    // Mover stalls 5 cycles in ISSUE while requester 2 also waits (ptr = 1).
    step();
    mover_lat  = 2;
    stall_left = 6;
    exp_grant.push_back(1);
    exp_mov.push_back('{64'h5000, 64'h100});
    exp_resp.push_back('{1'b0, 1});
    exp_grant.push_back(2);
    exp_resp.push_back('{1'b0, 2});
    set_req(1, 64'h5000, 64'h100, 1);
    set_req(2, 64'h5800, 64'h0, 1);
    wait_mvalid(20);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) sample();
      check("stall_m_valid",   64'(bus.m_valid),   64'd1);
      check("stall_m_src",     bus.m_src,          64'h5000);
      check("stall_m_len",     bus.m_len,          64'h100);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    wait_idle(60);
    check("stall_xfer_cnt", 64'(xfer_cnt), 64'd9);

    // Reset during WAIT_DONE (ptr = 3, requester 1 granted -> ptr 2).
    step();
    mover_lat = 20;
    exp_grant.push_back(1);
    exp_mov.push_back('{64'h6000, 64'h40});
    set_req(1, 64'h6000, 64'h40, 1);
    wait_mvalid(20);
    repeat (4) sample();
    check("pre_reset_busy",  64'(busy),  64'd1);
    check("pre_reset_owner", 64'(owner), 64'd1);
    step();
    areset = 1'b1;
    set_req(0, 64'h8000, 64'h40, 1);
    set_req(2, 64'h8800, 64'h40, 1);
    sample();
    check_reset_state("midreset");
    step();
    step();
    mover_lat = 2;
    exp_grant.push_back(0);
    exp_mov.push_back('{64'h8000, 64'h40});
    exp_resp.push_back('{1'b0, 0});
    exp_grant.push_back(2);
    exp_mov.push_back('{64'h8800, 64'h40});
    exp_resp.push_back('{1'b0, 2});
    areset = 1'b0;
    wait_idle(100);
    check("post_reset_xfer_cnt", 64'(xfer_cnt), 64'd2);

    repeat (5) sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
